// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and status strobes out.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] dataOut;
  logic       valid;
  logic       framingError;
  logic       busy;

  modport master (
    input  uart_rx,
    output dataOut, valid, framingError, busy
  );

  modport slave (
    output uart_rx,
    input  dataOut, valid, framingError, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input synchroniser, mid-bit sampling and
// single-cycle valid / framingError strobes.
module uart_rx #(
  parameter int unsigned CLOCK_SPEED = 50000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic      clock,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int unsigned CLOCK_DELAY = CLOCK_SPEED / BAUD_RATE;
  localparam int unsigned HALF_DELAY  = CLOCK_DELAY / 2;
  localparam logic [31:0] HALF_LAST   = 32'(HALF_DELAY - 1);
  localparam logic [31:0] BIT_LAST    = 32'(CLOCK_DELAY - 1);

  generate
    if (CLOCK_DELAY < 4) begin : g_bad_delay
      $error("uart_rx: CLOCK_DELAY must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic        sync1, rx_s;
  logic [31:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  shreg, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        armed, armed_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;

  // Two-flop synchroniser; line idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      armed   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      idx     <= idx_d;
      shreg   <= shreg_d;
      data_q  <= data_d;
      armed   <= armed_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // armed records that the line was seen idle-high, so a held break cannot retrigger.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    data_d  = data_q;
    armed_d = armed;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d        = '0;
          shreg_d[idx] = rx_s;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shreg;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.dataOut      = data_q;
  assign bus.valid        = valid_q;
  assign bus.framingError = ferr_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: table vectors,
// hand-written corner sequences and random frames against a byte-level model.
module tb_uart_rx;

  localparam int CD   = 16;
  localparam int HALF = CD / 2;
  // Strobe edge relative to E0: 2 sync edges, half-bit start check, 8 data + stop bits.
  localparam int LAT  = 2 + HALF + 9 * CD;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  uart_rx_if bus();

  uart_rx #(.CLOCK_SPEED(16), .BAUD_RATE(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_valid;
    logic [7:0] dout;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_strobe = 0;
  logic [7:0] last_good;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Called at a negedge; the next posedge is E0 of this frame.
  task automatic send_and_expect(input logic [7:0] d, input bit stop,
                                 input bit ev, input logic [7:0] ed);
    exp_t       e;
    logic [9:0] bits;
    e.cyc      = cyc + 1 + LAT;
    e.is_valid = ev;
    e.dout     = ed;
    exp_q.push_back(e);
    bits = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bus.uart_rx = bits[k];
      repeat (CD) @(negedge clock);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    chk(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (bus.valid || bus.framingError) begin
      exp_t e;
      n_strobe++;
      chk("strobe_exclusive", int'(bus.valid && bus.framingError), 0);
      chk("busy_at_strobe", int'(bus.busy), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: valid=%0b framingError=%0b dataOut=0x%0h at cycle %0d, none required",
                 bus.valid, bus.framingError, bus.dataOut, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_kind_valid", int'(bus.valid), int'(e.is_valid));
        chk("strobe_dataOut", int'(bus.dataOut), int'(e.dout));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[4];
    logic [7:0] d;
    bit         stop;
    int         gap;
    int         busy_cnt;
    int         strobes_before;
    logic [9:0] bits;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 20, exp_valid: 1'b1, exp_dout: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_valid: 1'b1, exp_dout: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 20, exp_valid: 1'b1, exp_dout: 8'hFF};
    vecs[3] = '{data: 8'h55, stop: 1'b0, gap: 20, exp_valid: 1'b0, exp_dout: 8'hFF};

    bus.uart_rx = 1'b1;
    reset_n     = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_dataOut", int'(bus.dataOut), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_framingError", int'(bus.framingError), 0);
    chk("reset_busy", int'(bus.busy), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    last_good = 8'h00;

    // Table vectors: single frame, back-to-back 0x00/0xFF, bad stop bit.
    for (int i = 0; i < 4; i++) begin
      send_and_expect(vecs[i].data, vecs[i].stop, vecs[i].exp_valid, vecs[i].exp_dout);
      bus.uart_rx = 1'b1;
      repeat (vecs[i].gap) @(negedge clock);
    end
    drain("table_drain");
    last_good = 8'hFF;
    chk("table_final_dataOut", int'(bus.dataOut), 8'hFF);

    // Three-cycle low glitch: busy for 8 cycles, no strobe.
    repeat (10) @(negedge clock);
    strobes_before = n_strobe;
    bus.uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    bus.uart_rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      busy_cnt += int'(bus.busy);
      @(negedge clock);
    end
    chk("glitch_busy_cycles", busy_cnt, 8);
    chk("glitch_no_strobe", n_strobe, strobes_before);
    chk("glitch_dataOut", int'(bus.dataOut), int'(last_good));

    // Break: bad stop bit, line held low, then recovery frame.
    send_and_expect(8'h3C, 1'b0, 1'b0, last_good);
    repeat (40) @(negedge clock);
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clock);
    send_and_expect(8'h81, 1'b1, 1'b1, 8'h81);
    last_good = 8'h81;
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clock);
    drain("break_drain");

    // Reset in the middle of data bit 4 of 0x5A.
    strobes_before = n_strobe;
    bits = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 6; k++) begin
      bus.uart_rx = bits[k];
      repeat ((k == 5) ? HALF : CD) @(negedge clock);
    end
    chk("midframe_busy", int'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_dataOut", int'(bus.dataOut), 0);
    chk("abort_valid", int'(bus.valid), 0);
    chk("abort_framingError", int'(bus.framingError), 0);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clock);
    bus.uart_rx = 1'b1;
    reset_n     = 1'b1;
    repeat (200) @(negedge clock);
    chk("abort_no_strobe", n_strobe, strobes_before);
    last_good = 8'h00;
    send_and_expect(8'h12, 1'b1, 1'b1, 8'h12);
    last_good = 8'h12;
    bus.uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    drain("after_reset_drain");

    // Random frames against the byte-level model.
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      send_and_expect(d, stop, stop, stop ? d : last_good);
      if (stop) last_good = d;
      bus.uart_rx = 1'b1;
      repeat (gap) @(negedge clock);
    end
    drain("random_drain");

    // Continuous stream 0x00..0xFF with no idle gap.
    for (int b = 0; b < 256; b++) begin
      send_and_expect(8'(b), 1'b1, 1'b1, 8'(b));
      last_good = 8'(b);
    end
    bus.uart_rx = 1'b1;
    drain("stream_drain");
    chk("stream_final_dataOut", int'(bus.dataOut), 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
